// File: rtl/board_io_conditioner_if.sv
// Core-facing side of the board I/O conditioner.
// The conditioner is the master; the core is the slave.
interface board_io_conditioner_if #(
  parameter int N_BTN = 1,
  parameter int N_LED = 6
);
  logic [N_LED-1:0] i_led;
  logic [N_BTN-1:0] o_btn;
  logic [N_BTN-1:0] o_btn_press;
  logic             o_tick;
  logic             o_cpu_ce;

  modport master (
    input  i_led,
    output o_btn,
    output o_btn_press,
    output o_tick,
    output o_cpu_ce
  );

  modport slave (
    output i_led,
    input  o_btn,
    input  o_btn_press,
    input  o_tick,
    input  o_cpu_ce
  );
endinterface

// File: rtl/board_io_conditioner.sv
// Board I/O front end: button sync/debounce, press pulses,
// run/step clock-enable generation and LED polarity.
module board_io_conditioner #(
  parameter int DIV_COUNT      = 1350000,
  parameter int DB_CYCLES      = 270000,
  parameter int N_BTN          = 1,
  parameter bit BTN_ACTIVE_LOW = 1'b1,
  parameter int STEP_BTN       = 0,
  parameter int N_LED          = 6,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn_pin,
  input  logic             i_mode_step,
  output logic [N_LED-1:0] o_led_pin,
  board_io_conditioner_if.master core
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = $clog2(DIV_COUNT);

  localparam logic [N_BTN-1:0] BTN_REL =
    BTN_ACTIVE_LOW ? '1 : '0;
  localparam logic [N_LED-1:0] LED_OFF =
    LED_ACTIVE_LOW ? '1 : '0;
  localparam logic [DBW-1:0] DB_LAST =
    DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST =
    TW'(DIV_COUNT - 1);

  logic [N_BTN-1:0] btn_s1_q, btn_s2_q;
  logic             mode_s1_q, mode_s2_q;
  logic [N_BTN-1:0] synced, diff;
  logic [N_BTN-1:0] btn_q, btn_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [DBW-1:0]   cnt_q [N_BTN];
  logic [DBW-1:0]   cnt_d [N_BTN];
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             tick_q, tick_d;
  logic             ce_q, ce_d;
  logic [N_LED-1:0] led_q, led_d;

  assign synced = btn_s2_q ^ BTN_REL;
  assign diff   = synced ^ btn_q;

  always_comb begin
    btn_d = btn_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      unique case (1'b1)
        !diff[i]:
          cnt_d[i] = '0;
        diff[i] && (cnt_q[i] == DB_LAST):
          btn_d[i] = synced[i];
        diff[i] && (cnt_q[i] != DB_LAST):
          cnt_d[i] = cnt_q[i] + 1'b1;
      endcase
    end
    press_d = btn_d & ~btn_q;

    tick_d = (tcnt_q == T_LAST);
    tcnt_d = tick_d ? '0 : tcnt_q + 1'b1;

    // guard keeps the enable single-cycle across a mode flip
    ce_d = (mode_s2_q ? press_d[STEP_BTN] : tick_d) & ~ce_q;

    led_d = core.i_led ^ LED_OFF;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      btn_s1_q  <= BTN_REL;
      btn_s2_q  <= BTN_REL;
      mode_s1_q <= 1'b0;
      mode_s2_q <= 1'b0;
      btn_q     <= '0;
      press_q   <= '0;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
      tcnt_q    <= '0;
      tick_q    <= 1'b0;
      ce_q      <= 1'b0;
      led_q     <= LED_OFF;
    end else begin
      btn_s1_q  <= i_btn_pin;
      btn_s2_q  <= btn_s1_q;
      mode_s1_q <= i_mode_step;
      mode_s2_q <= mode_s1_q;
      btn_q     <= btn_d;
      press_q   <= press_d;
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
      tcnt_q    <= tcnt_d;
      tick_q    <= tick_d;
      ce_q      <= ce_d;
      led_q     <= led_d;
    end
  end

  assign core.o_btn       = btn_q;
  assign core.o_btn_press = press_q;
  assign core.o_tick      = tick_q;
  assign core.o_cpu_ce    = ce_q;
  assign o_led_pin        = led_q;
endmodule

// File: doc/board_io_conditioner.md
Name: board_io_conditioner

Overview:
Parametrised board-level I/O front end between FPGA pins and the Z16 core.
- Synchronises and debounces N_BTN push-buttons and produces one-cycle press pulses.
- Generates a periodic clock-enable for the core in run mode, or one enable per step-button press in single-step mode.
- Drives N_LED LED pins with configurable polarity.
- Replaces derived-clock division: the core runs on i_clk and is gated by o_cpu_ce.

Parameters:
- DIV_COUNT, 1350000, i_clk cycles per run-mode enable pulse (>=2)
- DB_CYCLES, 270000, consecutive stable cycles required to accept a button change (>=1)
- N_BTN, 1, number of button channels (1..8)
- BTN_ACTIVE_LOW, 1, 1 = pin reads 0 when pressed
- STEP_BTN, 0, index of the button used as single-step (< N_BTN)
- N_LED, 6, number of LED channels
- LED_ACTIVE_LOW, 1, 1 = pin driven 0 lights the LED

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  reset; asynchronous assert, active-low (0 = reset); synchronous release is the board's responsibility
- i_btn_pin  input  N_BTN  raw button pins, asynchronous to i_clk
- i_mode_step  input  1  raw switch, asynchronous; 1 = single-step, 0 = run
- i_led  input  N_LED  LED request from core, 1 = lit
- o_led_pin  output  N_LED  LED pins, polarity per LED_ACTIVE_LOW
- o_btn  output  N_BTN  debounced button level, 1 = pressed
- o_btn_press  output  N_BTN  one-cycle pulse on debounced press
- o_tick  output  1  one-cycle pulse every DIV_COUNT cycles
- o_cpu_ce  output  1  one-cycle core clock-enable

Behaviour:
- Reset (i_rst=0) forces all of the following at once:
  - o_btn=0, o_btn_press=0, o_tick=0, o_cpu_ce=0
  - o_led_pin = all-off level: all 1s if LED_ACTIVE_LOW, else all 0s
  - synchronizer flops hold the released level; debounce counters and the tick counter are 0; synced mode = 0 (run)
- Input sync:
  - Each button bit and i_mode_step pass through a 2-flop synchroniser.
  - Button bits are inverted after syncing when BTN_ACTIVE_LOW=1.
- Debounce, per channel, counter width clog2(DB_CYCLES+1):
  - synced == o_btn: counter <= 0.
  - synced != o_btn and counter == DB_CYCLES-1: o_btn <= synced, counter <= 0.
  - otherwise: counter increments.
  - Any glitch that returns to the stable level clears the counter.
  - Latency from a clean pin edge to an o_btn change is 2+DB_CYCLES cycles.
- Press pulse: o_btn_press[i] is registered and goes high in the same cycle o_btn[i] goes 0->1, for exactly 1 cycle. A release produces no pulse. Channels are independent, and simultaneous presses pulse together.
- Tick:
  - Counter runs 0..DIV_COUNT-1 and wraps to 0.
  - o_tick is registered and high for the one cycle after the counter equals DIV_COUNT-1.
  - The first pulse comes DIV_COUNT cycles after reset release; the period is exactly DIV_COUNT.
  - The counter runs in both modes.
- Clock enable, registered:
  - Run mode: o_cpu_ce follows the o_tick pulse condition, so it coincides with o_tick.
  - Step mode: o_cpu_ce pulses coincident with o_btn_press[STEP_BTN].
  - A mode change takes effect 2 cycles after the pin changes.
  - A tick or press that lands in the opposite mode is dropped, never queued.
  - o_cpu_ce is never high on 2 consecutive cycles.
- LEDs: o_led_pin <= LED_ACTIVE_LOW ? ~i_led : i_led, registered, 1-cycle latency.
- Reset asserted mid-debounce or mid-count discards partial state. The first tick comes DIV_COUNT cycles after release, and no press pulse is generated on release from reset.

Test Plan:
Bench parameters: DIV_COUNT=4, DB_CYCLES=3, N_BTN=2, STEP_BTN=1, N_LED=6, both polarities active-low.
- Reset then release, mode=0 -> o_tick and o_cpu_ce pulse at cycles 4, 8, 12; o_led_pin=6'b111111 during reset.
- i_btn_pin[0] 1->0 held -> o_btn[0] rises 5 cycles later with a single o_btn_press[0] pulse; release -> o_btn[0] falls 5 cycles later with no pulse.
- i_btn_pin[0] glitch low for 2 cycles -> o_btn[0] stays 0; glitch low 2 cycles, high 1, low held -> acceptance counted from the final low.
- Mode=1, press STEP_BTN three times -> exactly 3 o_cpu_ce pulses, each aligned with o_btn_press[1]; o_tick continues and produces no o_cpu_ce.
- i_led=6'b000101 -> o_led_pin=6'b111010 one cycle later.
- Assert i_rst mid-debounce with o_btn[0]=0 while the pin is held low -> after release, o_btn[0] rises 5 cycles after release with no early pulse.
